// File: rtl/game_pkg.sv
// Shared encodings for the game sequencer: one-hot state layout and a width helper.
package game_pkg;

   localparam int unsigned S_INIT     = 0;
   localparam int unsigned S_READY    = 1;
   localparam int unsigned S_ARM      = 2;
   localparam int unsigned S_PLAY     = 3;
   localparam int unsigned S_DYING    = 4;
   localparam int unsigned S_OVER     = 5;
   localparam int unsigned NUM_STATES = 6;

   typedef enum logic [NUM_STATES-1:0] {
      StInit  = 6'b000001,
      StReady = 6'b000010,
      StArm   = 6'b000100,
      StPlay  = 6'b001000,
      StDying = 6'b010000,
      StOver  = 6'b100000
   } state_e;

   // Ceiling log2; used to size counters from their maximum count.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      while ((longint'(1) << result) < longint'(value)) begin
         result++;
      end
      return result;
   endfunction

endpackage

// File: rtl/hold_timer.sv
// Down-counter loaded with HOLD_CYCLES-1; tc flags the final cycle of a hold period.
module hold_timer
   import game_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES = 50_000_000,
   localparam int unsigned TW = clog2(HOLD_CYCLES)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic          enable,
   output logic [TW-1:0] count,
   output logic          tc
);

   logic [TW-1:0] count_q, count_d;

   // The caller gates enable at zero, so the count never wraps.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = TW'(HOLD_CYCLES - 1);
      end else if (enable) begin
         count_d = count_q - TW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign tc    = (count_q == '0);

endmodule

// File: rtl/game_ctrl_fsm.sv
// Game sequencer: one-hot FSM with internal lives counter and hold timer for DYING/OVER.
module game_ctrl_fsm
   import game_pkg::*;
#(
   parameter int unsigned N_BTN       = 2,
   parameter int unsigned MAX_LIVES   = 3,
   parameter int unsigned HOLD_CYCLES = 50_000_000,
   localparam int unsigned LW = clog2(MAX_LIVES + 1),
   localparam int unsigned TW = clog2(HOLD_CYCLES)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  middle,
   input  logic [N_BTN-1:0]      btn,
   input  logic                  spike,
   input  logic                  extra_life,
   output logic [NUM_STATES-1:0] state,
   output logic [LW-1:0]         lives,
   output logic                  halt,
   output logic                  game,
   output logic                  load_play,
   output logic                  load_life,
   output logic                  reload,
   output logic                  restart,
   output logic                  dead,
   output logic                  game_over
);

   localparam logic [LW:0] MaxLives = (LW + 1)'(MAX_LIVES);

   logic [NUM_STATES-1:0] state_q, state_d;
   logic [LW-1:0]         lives_q, lives_d;
   logic [LW:0]           lives_sum, lives_eff;
   logic [TW-1:0]         timer;
   logic                  tc, timer_load, timer_en, in_hold;

   assign in_hold = state_q[S_DYING] | state_q[S_OVER];

   // Extra life is folded in before the spike decision, so a simultaneous bonus cancels the hit.
   assign lives_sum = {1'b0, lives_q} + {{LW{1'b0}}, extra_life};
   assign lives_eff = (lives_sum > MaxLives) ? MaxLives : lives_sum;

   always_comb begin
      state_d = state_q;
      lives_d = lives_q;
      unique case (state_q)
         StInit: begin
            state_d = StReady;
            lives_d = LW'(MAX_LIVES);
         end
         StReady: begin
            if (middle) state_d = StArm;
         end
         StArm: begin
            if (|btn) begin
               state_d = StPlay;
            end else if (!middle) begin
               state_d = StReady;
            end
         end
         StPlay: begin
            if (spike) begin
               if (lives_eff > (LW + 1)'(1)) begin
                  state_d = StDying;
                  lives_d = LW'(lives_eff - (LW + 1)'(1));
               end else begin
                  state_d = StOver;
                  lives_d = '0;
               end
            end else begin
               lives_d = LW'(lives_eff);
            end
         end
         StDying: begin
            if (tc) state_d = StReady;
         end
         StOver: begin
            if (tc) state_d = StInit;
         end
         default: state_d = StInit;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StInit;
         lives_q <= '0;
      end else begin
         state_q <= state_d;
         lives_q <= lives_d;
      end
   end

   assign timer_load = state_q[S_PLAY] & (state_d[S_DYING] | state_d[S_OVER]);
   assign timer_en   = in_hold & (timer != '0);

   hold_timer #(
      .HOLD_CYCLES(HOLD_CYCLES)
   ) u_hold_timer (
      .clk   (clk),
      .rst   (rst),
      .load  (timer_load),
      .enable(timer_en),
      .count (timer),
      .tc    (tc)
   );

   assign state     = state_q;
   assign lives     = lives_q;
   assign halt      = state_q[S_ARM] | state_q[S_DYING] | state_q[S_OVER];
   assign game      = state_q[S_ARM] | state_q[S_PLAY] | state_q[S_DYING];
   assign load_play = state_q[S_ARM];
   assign load_life = state_q[S_INIT];
   assign dead      = in_hold;
   assign game_over = state_q[S_OVER];
   assign reload    = state_q[S_DYING] & tc;
   assign restart   = state_q[S_OVER] & tc;

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Directed self-checking bench for game_ctrl_fsm with HOLD_CYCLES=4, MAX_LIVES=3.
module tb_game_ctrl_fsm;

   localparam logic [5:0] ST_INIT  = 6'b000001;
   localparam logic [5:0] ST_READY = 6'b000010;
   localparam logic [5:0] ST_ARM   = 6'b000100;
   localparam logic [5:0] ST_PLAY  = 6'b001000;
   localparam logic [5:0] ST_DYING = 6'b010000;
   localparam logic [5:0] ST_OVER  = 6'b100000;

   logic       clk = 1'b0;
   logic       rst, middle, spike, extra_life;
   logic [1:0] btn;
   logic [5:0] state;
   logic [1:0] lives;
   logic       halt, game, load_play, load_life, reload, restart, dead, game_over;

   logic       middle4;
   logic [3:0] btn4;
   logic [5:0] state4;
   logic [1:0] lives4;
   logic       halt4, game4, load_play4, load_life4, reload4, restart4, dead4, game_over4;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   game_ctrl_fsm #(.N_BTN(2), .MAX_LIVES(3), .HOLD_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .middle(middle), .btn(btn), .spike(spike),
      .extra_life(extra_life), .state(state), .lives(lives), .halt(halt), .game(game),
      .load_play(load_play), .load_life(load_life), .reload(reload), .restart(restart),
      .dead(dead), .game_over(game_over)
   );

   game_ctrl_fsm #(.N_BTN(4), .MAX_LIVES(3), .HOLD_CYCLES(4)) dut4 (
      .clk(clk), .rst(rst), .middle(middle4), .btn(btn4), .spike(1'b0),
      .extra_life(1'b0), .state(state4), .lives(lives4), .halt(halt4), .game(game4),
      .load_play(load_play4), .load_life(load_life4), .reload(reload4), .restart(restart4),
      .dead(dead4), .game_over(game_over4)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic go_play();
      middle = 1'b1;
      tick();
      btn = 2'b01;
      tick();
      btn = 2'b00;
      middle = 1'b0;
   endtask

   task automatic hold4();
      for (int i = 0; i < 4; i++) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++; if (state !== ST_INIT) begin bad++; $display("FAIL rst_state got %b want %b", state, ST_INIT); end
      total++; if (lives !== 2'd0) begin bad++; $display("FAIL rst_lives got %0d want 0", lives); end
      total++; if ({load_life, halt, game, load_play, reload, restart, dead, game_over} !== 8'b1000_0000) begin
         bad++; $display("FAIL rst_outputs got %b want 10000000",
                         {load_life, halt, game, load_play, reload, restart, dead, game_over});
      end
      tick();
      total++; if (state !== ST_READY) begin bad++; $display("FAIL ready_state got %b want %b", state, ST_READY); end
      total++; if (lives !== 2'd3) begin bad++; $display("FAIL ready_lives got %0d want 3", lives); end
      total++; if ({halt, game, load_life} !== 3'b000) begin
         bad++; $display("FAIL ready_outs got %b want 000", {halt, game, load_life});
      end
   endtask

   task automatic test_btn4();
      middle4 = 1'b1;
      tick();
      total++; if (state4 !== ST_ARM) begin bad++; $display("FAIL n4_arm got %b want %b", state4, ST_ARM); end
      btn4 = 4'b0100;
      tick();
      total++; if (state4 !== ST_PLAY) begin bad++; $display("FAIL n4_play got %b want %b", state4, ST_PLAY); end
      btn4 = 4'b0000;
      middle4 = 1'b0;
   endtask

   task automatic test_arm_play();
      btn = 2'b01;
      tick();
      total++; if (state !== ST_READY) begin bad++; $display("FAIL btn_ignored got %b want %b", state, ST_READY); end
      btn = 2'b00;
      middle = 1'b1;
      tick();
      total++; if (state !== ST_ARM) begin bad++; $display("FAIL arm_state got %b want %b", state, ST_ARM); end
      total++; if ({halt, load_play, game} !== 3'b111) begin
         bad++; $display("FAIL arm_outs got %b want 111", {halt, load_play, game});
      end
      middle = 1'b0;
      tick();
      total++; if (state !== ST_READY) begin bad++; $display("FAIL arm_release got %b want %b", state, ST_READY); end
      middle = 1'b1;
      tick();
      middle = 1'b0;
      btn = 2'b10;
      tick();
      total++; if (state !== ST_PLAY) begin bad++; $display("FAIL btn_beats_release got %b want %b", state, ST_PLAY); end
      total++; if ({game, halt, load_play} !== 3'b100) begin
         bad++; $display("FAIL play_outs got %b want 100", {game, halt, load_play});
      end
      btn = 2'b00;
      middle = 1'b1;
      tick();
      total++; if (state !== ST_PLAY) begin bad++; $display("FAIL play_stays got %b want %b", state, ST_PLAY); end
      middle = 1'b0;
   endtask

   task automatic test_dying();
      spike = 1'b1;
      tick();
      spike = 1'b0;
      total++; if (lives !== 2'd2) begin bad++; $display("FAIL dying_lives got %0d want 2", lives); end
      for (int k = 1; k <= 4; k++) begin
         total++; if ({state, dead, reload} !== {ST_DYING, 1'b1, (k == 4)}) begin
            bad++; $display("FAIL dying_cycle%0d got %b want %b", k, {state, dead, reload},
                            {ST_DYING, 1'b1, (k == 4)});
         end
         tick();
      end
      total++; if (state !== ST_READY) begin bad++; $display("FAIL dying_exit got %b want %b", state, ST_READY); end
   endtask

   task automatic test_over();
      go_play();
      total++; if (state !== ST_PLAY) begin bad++; $display("FAIL btn01_play got %b want %b", state, ST_PLAY); end
      spike = 1'b1;
      tick();
      spike = 1'b0;
      hold4();
      go_play();
      spike = 1'b1;
      tick();
      spike = 1'b0;
      total++; if (lives !== 2'd0) begin bad++; $display("FAIL over_lives got %0d want 0", lives); end
      for (int k = 1; k <= 4; k++) begin
         total++; if ({state, game_over, halt, game, restart} !== {ST_OVER, 3'b110, (k == 4)}) begin
            bad++; $display("FAIL over_cycle%0d got %b want %b", k,
                            {state, game_over, halt, game, restart}, {ST_OVER, 3'b110, (k == 4)});
         end
         tick();
      end
      total++; if ({state, load_life} !== {ST_INIT, 1'b1}) begin
         bad++; $display("FAIL over_exit got %b want %b", {state, load_life}, {ST_INIT, 1'b1});
      end
      tick();
      total++; if (lives !== 2'd3) begin bad++; $display("FAIL relive got %0d want 3", lives); end
   endtask

   task automatic test_extra_life();
      go_play();
      extra_life = 1'b1;
      tick();
      extra_life = 1'b0;
      total++; if (lives !== 2'd3) begin bad++; $display("FAIL extra_sat got %0d want 3", lives); end
      spike = 1'b1;
      tick();
      spike = 1'b0;
      hold4();
      go_play();
      extra_life = 1'b1;
      tick();
      extra_life = 1'b0;
      total++; if (lives !== 2'd3) begin bad++; $display("FAIL extra_inc got %0d want 3", lives); end
      spike = 1'b1;
      tick();
      spike = 1'b0;
      hold4();
      go_play();
      spike = 1'b1;
      tick();
      spike = 1'b0;
      hold4();
      go_play();
      spike = 1'b1;
      extra_life = 1'b1;
      tick();
      spike = 1'b0;
      extra_life = 1'b0;
      total++; if ({state, lives} !== {ST_DYING, 2'd1}) begin
         bad++; $display("FAIL spike_extra got %b want %b", {state, lives}, {ST_DYING, 2'd1});
      end
      hold4();
      spike = 1'b1;
      extra_life = 1'b1;
      tick();
      spike = 1'b0;
      extra_life = 1'b0;
      total++; if ({state, lives} !== {ST_READY, 2'd1}) begin
         bad++; $display("FAIL ignored_in_ready got %b want %b", {state, lives}, {ST_READY, 2'd1});
      end
   endtask

   task automatic test_reset_mid();
      go_play();
      spike = 1'b1;
      tick();
      spike = 1'b0;
      tick();
      total++; if (dut.u_hold_timer.count !== 2'd2) begin
         bad++; $display("FAIL timer_two got %0d want 2", dut.u_hold_timer.count);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++; if ({state, reload, lives} !== {ST_INIT, 1'b0, 2'd0}) begin
         bad++; $display("FAIL mid_reset got %b want %b", {state, reload, lives}, {ST_INIT, 3'b000});
      end
      total++; if (dut.u_hold_timer.count !== 2'd0) begin
         bad++; $display("FAIL mid_reset_timer got %0d want 0", dut.u_hold_timer.count);
      end
      tick();
      total++; if ({state, reload} !== {ST_READY, 1'b0}) begin
         bad++; $display("FAIL after_reset got %b want %b", {state, reload}, {ST_READY, 1'b0});
      end
   endtask

   task automatic test_illegal();
      force dut.state_q = 6'b000011;
      #1;
      total++; if (dut.state_d !== ST_INIT) begin
         bad++; $display("FAIL illegal_next got %b want %b", dut.state_d, ST_INIT);
      end
      release dut.state_q;
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; middle = 1'b0; btn = 2'b00; spike = 1'b0; extra_life = 1'b0;
      middle4 = 1'b0; btn4 = 4'b0000;
      test_reset();
      test_btn4();
      test_arm_play();
      test_dying();
      test_over();
      test_extra_life();
      test_reset_mid();
      test_illegal();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/game_ctrl_fsm.md
Name: game_ctrl_fsm

Overview:
- Parametrised, registered successor to the one-hot game sequencer.
- Owns the state register, a lives counter and a hold timer internally, so no external TC or LIFE inputs are needed.
- Adds N_BTN start buttons, configurable lives and hold time, and an extra-life input.
- Sits between the debounced pushbutton/sensor inputs and the play-field, score and display logic.

Parameters:
- N_BTN, 2, number of start pushbuttons (any one starts play).
- MAX_LIVES, 3, lives loaded at game start (>=1).
- HOLD_CYCLES, 50_000_000, cycles spent in DYING and OVER before advancing (>=2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- middle  in  1  centre switch held (arms play).
- btn  in  N_BTN  start pushbuttons, level-sensitive, already debounced.
- spike  in  1  player hit hazard; sampled only in PLAY.
- extra_life  in  1  single-cycle bonus pulse; sampled only in PLAY.
- state  out  6  one-hot state: [0]INIT [1]READY [2]ARM [3]PLAY [4]DYING [5]OVER.
- lives  out  LW  remaining lives, LW = clog2(MAX_LIVES+1).
- halt  out  1  freeze play-field motion.
- game  out  1  game session active.
- load_play  out  1  load play-field start position.
- load_life  out  1  load life display.
- reload  out  1  one-cycle pulse, DYING to READY.
- restart  out  1  one-cycle pulse, OVER to INIT.
- dead  out  1  death animation active.
- game_over  out  1  game-over display active.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high. All state is registered on the rising edge of clk.
- Reset values: state=000001 (INIT), lives=0, timer=0. Outputs follow the decode of INIT: load_life=1, all other outputs 0.
- Output decode (Moore, combinational from registered state):
  - halt = ARM|DYING|OVER
  - game = ARM|PLAY|DYING
  - load_play = ARM
  - load_life = INIT
  - dead = DYING|OVER
  - game_over = OVER
- Pulses (registered-state based, high on the last hold cycle):
  - reload = DYING & tc
  - restart = OVER & tc
  - tc = (timer==0)
- Transitions:
  - INIT -> READY unconditionally after 1 cycle; lives <= MAX_LIVES.
  - READY -> ARM when middle=1, else stay in READY.
  - ARM -> PLAY when |btn=1. Otherwise ARM -> READY if middle=0, else stay in ARM. A button press beats middle release.
  - PLAY, spike=1, effective lives > 1 -> DYING; lives decrements.
  - PLAY, spike=1, effective lives == 1 -> OVER; lives <= 0.
  - DYING -> READY on tc.
  - OVER -> INIT on tc.
- Effective lives in PLAY = lives + extra_life, saturated at MAX_LIVES.
  - extra_life alone: lives increments, saturating (no wrap).
  - spike and extra_life in the same cycle: lives stays unchanged (when lives < MAX_LIVES), next state is DYING.
- Timer:
  - Width clog2(HOLD_CYCLES).
  - Loaded with HOLD_CYCLES-1 on the cycle the FSM enters DYING or OVER.
  - Decrements each cycle while in DYING/OVER; holds at 0 elsewhere.
  - Residency in DYING/OVER is exactly HOLD_CYCLES cycles.
- Ignored inputs: btn in non-ARM states, spike/extra_life outside PLAY, middle outside READY/ARM.
- Reset mid-operation (any state, any timer value): back to INIT next edge, timer cleared, no reload/restart pulse.
- Illegal state: any non-one-hot state vector recovers to INIT on the next edge.

Decomposition:
- Shared package game_pkg:
  - state index localparams S_INIT..S_OVER and the 6-bit one-hot encoding constants;
  - lives-width function clog2.
- One natural sub-module: hold_timer (load, enable, count, tc), parametrised by HOLD_CYCLES. It is reusable by other display and animation blocks.
- The FSM and lives counter stay in the top module.

Test Plan:
- Reset then idle, HOLD_CYCLES=4, MAX_LIVES=3 -> INIT 1 cycle with load_life=1; READY with lives=3, halt=0, game=0.
- middle=1, then btn=01 -> ARM with halt=1, load_play=1 for at least 1 cycle, then PLAY with game=1, halt=0. Repeat with btn=10 and N_BTN=4 (btn=0100).
- In PLAY, spike pulse with lives=3 -> DYING with lives=2, dead=1 for exactly 4 cycles; reload=1 on the 4th cycle; then READY.
- Lives=1, spike -> OVER with lives=0, game_over=1 for 4 cycles; restart pulse on the last cycle; then INIT and lives reloads to 3.
- Extra life and collision cases:
  - extra_life at lives=3 -> lives stays 3;
  - extra_life at lives=2 -> 3;
  - spike+extra_life together at lives=1 -> DYING with lives=1, not OVER.
- Assert rst during DYING at timer=2 -> INIT next cycle, no reload pulse. Force state=000011 -> INIT next cycle.
